uart_rx_ctrl: RTL

Receive-side controller for the SoC UART. Sits between the `uart_rx` bit-level receiver and the peripheral bus register file. Sequences the receiver enable, buffers received bytes in a show-ahead FIFO, and detects overrun. Raises a single interrupt on fill threshold, idle timeout or overrun.

---
 rtl/uart_rx_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: receiver enable sequencing, show-ahead RX FIFO,
// sticky overrun, idle timeout and a combined interrupt request.
//
// state | meaning
// OFF   | receiver disabled, rx_valid ignored
// RUN   | receiver enabled by software
// DRAIN | software disabled mid-frame; keep receiving until the frame ends
module uart_rx_ctrl #(
    parameter int PAYLOAD_BITS   = 8,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4340,
    parameter int CW             = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_enable,
    input  logic [CW-1:0]           cfg_thresh,
    input  logic                    flush,
    input  logic                    ovr_clr,
    output logic                    rx_en,
    input  logic                    rx_busy,
    input  logic                    rx_valid,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic [CW-1:0]           level,
    output logic                    overrun,
    output logic                    timeout,
    output logic                    irq,
    output logic                    clk_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           level_q,  level_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                    overrun_q, overrun_d;

    logic push_req, pop, full, push_acc, drop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_OFF;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:   if (cfg_enable) state_d = ST_RUN;
            ST_RUN:   if (!cfg_enable) state_d = rx_busy ? ST_DRAIN : ST_OFF;
            ST_DRAIN: begin
                if (cfg_enable)    state_d = ST_RUN;
                else if (!rx_busy) state_d = ST_OFF;
            end
            default:  state_d = ST_OFF;
        endcase
    end

    always_comb begin
        rx_en = (state_q != ST_OFF);
    end

    // A flush wins over everything: same-cycle push is discarded silently and pop is moot.
    assign push_req = rx_valid && (state_q != ST_OFF);
    assign full     = (level_q == CW'(DEPTH));
    assign pop      = rd_valid && rd_ready && !flush;
    assign push_acc = push_req && !flush && (!full || pop);
    assign drop     = push_req && !flush && full && !pop;

    always_comb begin
        level_d = level_q;
        if (flush)
            level_d = '0;
        else if (push_acc && !pop)
            level_d = level_q + CW'(1);
        else if (pop && !push_acc)
            level_d = level_q - CW'(1);
    end

    assign overrun_d = drop || (overrun_q && !ovr_clr);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (level_q == '0 || push_req || pop || flush)
            tmo_cnt_d = '0;
        else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES))
            tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tmo_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_acc) mem_q[wr_ptr_q] <= rx_data;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q   <= level_d;
            tmo_cnt_q <= tmo_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overrun  = overrun_q;
    assign timeout  = (tmo_cnt_q == TW'(TIMEOUT_CYCLES));
    assign irq      = ((cfg_thresh != '0) && (level_q >= cfg_thresh)) || timeout || overrun_q;
    assign clk_req  = (state_q != ST_OFF) || (level_q != '0);

endmodule
